// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - sizing and lane helpers shared by the FIFO word packer
package fifo_pack_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PACK_N = 4;
    localparam int KEEP_MAX_W = 32;

    function automatic int cnt_w(input int pack_n);
        return $clog2(pack_n + 1);
    endfunction

    // Lanes below cnt are valid; callers truncate to their own PACK_N.
    function automatic logic [KEEP_MAX_W-1:0] keep_from_cnt(input int cnt);
        return (KEEP_MAX_W'(1) << cnt) - KEEP_MAX_W'(1);
    endfunction

    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry valid/ready holding register for packed words
module stream_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              can_load_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              last_o
);

    // Free this cycle if empty or being drained, so load and accept can overlap.
    assign can_load_o = !valid_o || ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            keep_o  <= '0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            keep_o  <= keep_i;
            last_o  <= last_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs PACK_N FIFO entries per output word, with flush of partial words
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK_N = DEF_PACK_N
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    input  logic [DATA_W-1:0]        fifo_rd_data_i,
    input  logic                     flush_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_W*PACK_N-1:0] m_data_o,
    output logic [PACK_N-1:0]        m_keep_o,
    output logic                     m_last_o,
    output logic                     busy_o
);

    localparam int WORD_W = DATA_W * PACK_N;
    localparam int CNT_W  = cnt_w(PACK_N);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_N);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  fill;
    logic              rd_pend;
    logic              flush_pend;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_n;
    logic [PACK_N-1:0] keep;
    logic              want;
    logic              can_load;
    logic              xfer;
    logic              xfer_last;
    logic              flush_done;
    int                lane_base;

    assign want       = (cnt == CNT_FULL) || (flush_pend && !rd_pend && (cnt != '0));
    assign xfer       = want && can_load;
    assign xfer_last  = flush_pend && !rd_pend;
    assign flush_done = xfer_last && ((cnt == '0) || xfer);
    assign cnt_eff    = xfer ? '0 : cnt;
    assign fill       = cnt_eff + CNT_W'(rd_pend);
    assign keep       = PACK_N'(keep_from_cnt(int'(cnt)));
    assign lane_base  = lane_lsb(int'(cnt_eff), DATA_W);
    assign busy_o     = (cnt != '0) || rd_pend || flush_pend;

    // A pop that will land on a full accumulator is only issued when the
    // output register is certain to take that word on the landing edge.
    assign fifo_rd_en_o = !rst_i && !fifo_empty_i && !flush_pend &&
                          ((fill < CNT_FULL) ||
                           ((fill == CNT_FULL) && !xfer && can_load));

    always_comb begin
        acc_n = xfer ? '0 : acc;
        if (rd_pend) begin
            acc_n[lane_base +: DATA_W] = fifo_rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            rd_pend    <= 1'b0;
            flush_pend <= 1'b0;
            acc        <= '0;
        end else begin
            cnt     <= fill;
            rd_pend <= fifo_rd_en_o;
            acc     <= acc_n;
            if (flush_pend) begin
                flush_pend <= !flush_done;
            end else begin
                flush_pend <= flush_i;
            end
        end
    end

    stream_out_reg #(
        .DATA_W(WORD_W),
        .KEEP_W(PACK_N)
    ) u_out (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (xfer),
        .data_i    (acc),
        .keep_i    (keep),
        .last_i    (xfer_last),
        .can_load_o(can_load),
        .valid_o   (m_valid_o),
        .ready_i   (m_ready_i),
        .data_o    (m_data_o),
        .keep_o    (m_keep_o),
        .last_o    (m_last_o)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed tests for fifo_word_packer against a FIFO read-side model
module tb_fifo_word_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fifo_empty_i;
    logic        fifo_rd_en_o;
    logic [7:0]  fifo_rd_data_i;
    logic        flush_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic        busy_o;

    int errors;
    int checks;

    logic [7:0] src [0:255];
    int avail;
    int rd_ptr;
    int pop_underflow;
    int cyc;

    logic [31:0] rx_data [$];
    logic [3:0]  rx_keep [$];
    logic        rx_last [$];
    int          rx_cyc  [$];

    always #5 clk_i = ~clk_i;

    fifo_word_packer #(
        .DATA_W(8),
        .PACK_N(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rd_en_o  (fifo_rd_en_o),
        .fifo_rd_data_i(fifo_rd_data_i),
        .flush_i       (flush_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_data_o      (m_data_o),
        .m_keep_o      (m_keep_o),
        .m_last_o      (m_last_o),
        .busy_o        (busy_o)
    );

    assign fifo_empty_i = (rd_ptr >= avail);

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (fifo_rd_en_o) begin
            if (rd_ptr >= avail) begin
                pop_underflow <= pop_underflow + 1;
            end else begin
                fifo_rd_data_i <= src[rd_ptr[7:0]];
                rd_ptr         <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && m_valid_o && m_ready_i) begin
            rx_data.push_back(m_data_o);
            rx_keep.push_back(m_keep_o);
            rx_last.push_back(m_last_o);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push(input logic [7:0] v);
        src[avail[7:0]] = v;
        avail = avail + 1;
    endtask

    task automatic test_reset();
        rst_i     = 1'b1;
        m_ready_i = 1'b0;
        flush_i   = 1'b0;
        tick();
        tick();
        checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
        checks++; if (m_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data_o); end
        checks++; if (m_keep_o !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h want 0", m_keep_o); end
        checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_last_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int n0;
        int p0;
        n0 = rx_data.size();
        p0 = rd_ptr;
        m_ready_i = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 30 && rx_data.size() < n0 + 1; i++) tick();
        tick();
        checks++;
        if (rx_data.size() != n0 + 1) begin
            errors++; $display("FAIL single_count: got %0d want %0d", rx_data.size() - n0, 1);
        end else begin
            checks++; if (rx_data[n0] !== 32'h44332211) begin errors++; $display("FAIL single_data: got %h want 44332211", rx_data[n0]); end
            checks++; if (rx_keep[n0] !== 4'hF) begin errors++; $display("FAIL single_keep: got %h want f", rx_keep[n0]); end
            checks++; if (rx_last[n0] !== 1'b0) begin errors++; $display("FAIL single_last: got %b want 0", rx_last[n0]); end
        end
        checks++; if (rd_ptr - p0 != 4) begin errors++; $display("FAIL single_pops: got %0d want 4", rd_ptr - p0); end
        checks++; if (pop_underflow != 0) begin errors++; $display("FAIL single_underflow: got %0d want 0", pop_underflow); end
        checks++; if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy_o, m_valid_o); end
    endtask

    task automatic test_stream();
        int n0;
        int hi;
        int gap;
        logic [31:0] exp_w [4];
        exp_w = '{32'h83828180, 32'h87868584, 32'h8b8a8988, 32'h8f8e8d8c};
        n0 = rx_data.size();
        hi = 0;
        gap = 0;
        m_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) push(8'(8'h80 + k));
        #1;
        for (int i = 0; i < 40; i++) begin
            if (fifo_rd_en_o) hi++;
            else if (hi > 0 && hi < 16) gap++;
            tick();
        end
        checks++; if (hi != 16) begin errors++; $display("FAIL stream_pops: got %0d want 16", hi); end
        checks++; if (gap != 0) begin errors++; $display("FAIL stream_pop_gaps: got %0d want 0", gap); end
        checks++;
        if (rx_data.size() != n0 + 4) begin
            errors++; $display("FAIL stream_count: got %0d want 4", rx_data.size() - n0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (rx_data[n0+j] !== exp_w[j] || rx_keep[n0+j] !== 4'hF || rx_last[n0+j] !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_word%0d: got %h/%h/%b want %h/f/0", j, rx_data[n0+j], rx_keep[n0+j], rx_last[n0+j], exp_w[j]);
                end
            end
            for (int j = 1; j < 4; j++) begin
                checks++;
                if (rx_cyc[n0+j] - rx_cyc[n0+j-1] != 4) begin
                    errors++; $display("FAIL stream_interval%0d: got %0d want 4", j, rx_cyc[n0+j] - rx_cyc[n0+j-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        int p0;
        int seen;
        int unstable;
        logic [31:0] exp_w [3];
        exp_w = '{32'hc3c2c1c0, 32'hc7c6c5c4, 32'hcbcac9c8};
        n0 = rx_data.size();
        p0 = rd_ptr;
        seen = 0;
        unstable = 0;
        m_ready_i = 1'b0;
        for (int k = 0; k < 12; k++) push(8'(8'hc0 + k));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid_o) begin
                seen++;
                if (m_data_o !== 32'hc3c2c1c0 || m_keep_o !== 4'hF || m_last_o !== 1'b0) unstable++;
            end
        end
        checks++; if (seen != 15) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 15", seen); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes want 0", unstable); end
        checks++; if (rd_ptr - p0 != 8) begin errors++; $display("FAIL bp_pops: got %0d want 8", rd_ptr - p0); end
        checks++; if (fifo_rd_en_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL bp_stalled: got rd_en=%b busy=%b want 0 1", fifo_rd_en_o, busy_o); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 40 && rx_data.size() < n0 + 3; i++) tick();
        checks++;
        if (rx_data.size() != n0 + 3) begin
            errors++; $display("FAIL bp_count: got %0d want 3", rx_data.size() - n0);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (rx_data[n0+j] !== exp_w[j] || rx_keep[n0+j] !== 4'hF) begin
                    errors++; $display("FAIL bp_word%0d: got %h/%h want %h/f", j, rx_data[n0+j], rx_keep[n0+j], exp_w[j]);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_flush_partial();
        int n0;
        int p0;
        n0 = rx_data.size();
        p0 = rd_ptr;
        m_ready_i = 1'b1;
        push(8'ha1); push(8'ha2);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        push(8'ha3);
        #1;
        checks++; if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL flush_blocks_pop: got %b want 0", fifo_rd_en_o); end
        tick();
        checks++; if (m_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b want 1", m_valid_o); end
        checks++; if (m_data_o !== 32'h0000a2a1) begin errors++; $display("FAIL flush_data: got %h want 0000a2a1", m_data_o); end
        checks++; if (m_keep_o !== 4'h3) begin errors++; $display("FAIL flush_keep: got %h want 3", m_keep_o); end
        checks++; if (m_last_o !== 1'b1) begin errors++; $display("FAIL flush_last: got %b want 1", m_last_o); end
        checks++; if (rd_ptr - p0 != 2) begin errors++; $display("FAIL flush_pops: got %0d want 2", rd_ptr - p0); end
        repeat (3) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 20 && rx_data.size() < n0 + 2; i++) tick();
        checks++;
        if (rx_data.size() != n0 + 2) begin
            errors++; $display("FAIL flush1_count: got %0d want 2", rx_data.size() - n0);
        end else begin
            checks++;
            if (rx_data[n0+1] !== 32'h000000a3 || rx_keep[n0+1] !== 4'h1 || rx_last[n0+1] !== 1'b1) begin
                errors++; $display("FAIL flush1_word: got %h/%h/%b want 000000a3/1/1", rx_data[n0+1], rx_keep[n0+1], rx_last[n0+1]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_flush_empty();
        int n0;
        int bh;
        int vh;
        n0 = rx_data.size();
        bh = 0;
        vh = 0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fe_idle_before: got %b want 0", busy_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy_o) bh++;
            if (m_valid_o) vh++;
            tick();
        end
        checks++; if (bh != 1) begin errors++; $display("FAIL fe_busy_cycles: got %0d want 1", bh); end
        checks++; if (vh != 0 || rx_data.size() != n0) begin errors++; $display("FAIL fe_no_output: got %0d valid cycles want 0", vh); end
    endtask

    task automatic test_reset_mid();
        int n0;
        m_ready_i = 1'b1;
        push(8'hd0); push(8'hd1); push(8'hd2);
        repeat (3) tick();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b want 1", busy_o); end
        rst_i = 1'b1;
        tick();
        checks++;
        if (m_valid_o !== 1'b0 || m_data_o !== 32'h0 || m_keep_o !== 4'h0 || m_last_o !== 1'b0 || busy_o !== 1'b0 || fifo_rd_en_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_outputs: got v=%b d=%h k=%h l=%b b=%b r=%b want all 0", m_valid_o, m_data_o, m_keep_o, m_last_o, busy_o, fifo_rd_en_o);
        end
        rst_i = 1'b0;
        n0 = rx_data.size();
        push(8'he0); push(8'he1); push(8'he2); push(8'he3);
        for (int i = 0; i < 30 && rx_data.size() < n0 + 1; i++) tick();
        checks++;
        if (rx_data.size() != n0 + 1) begin
            errors++; $display("FAIL rm_count: got %0d want 1", rx_data.size() - n0);
        end else begin
            checks++;
            if (rx_data[n0] !== 32'he3e2e1e0 || rx_keep[n0] !== 4'hF || rx_last[n0] !== 1'b0) begin
                errors++; $display("FAIL rm_word: got %h/%h/%b want e3e2e1e0/f/0", rx_data[n0], rx_keep[n0], rx_last[n0]);
            end
        end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        m_ready_i = 1'b0;
        flush_i   = 1'b0;
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_mid();
        checks++; if (pop_underflow != 0) begin errors++; $display("FAIL underflow_total: got %0d want 0", pop_underflow); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
